hs_monitor: RTL and testbench

- Parametrised, run-controlled debug monitor for the GAT pipeline. Generalises the fixed 4-stage vld/rdy sticky-flag debugger.
- Observes NUM_CH valid/ready channels (SPMM, DMVM, softmax, aggregation, ...). Keeps sticky flags, handshake/stall counters and first-valid timestamps per channel, plus NUM_TRIG address-triggered data captures.
- All results are read back through one registered, selectable 32-bit debug port to the ILA/VIO or AXI-lite status wrapper.

---
 rtl/hs_monitor_pkg.sv | 32 +++
 rtl/hs_ch_stat.sv | 65 ++++++
 rtl/hs_monitor.sv | 194 +++++++++++++++++++
 tb/tb_hs_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_monitor_pkg.sv
// hs_monitor_pkg: run-state encoding and readout map shared by the hs_monitor slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hs_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Readout select map; pages are selected by rd_sel[7:4], entries by rd_sel[3:0]
   localparam logic [7:0] SEL_STATUS = 8'h00;
   localparam logic [7:0] SEL_TIMER  = 8'h01;
   localparam logic [7:0] SEL_NCH    = 8'h02;
   localparam logic [7:0] SEL_NTRIG  = 8'h03;
   localparam logic [7:0] SEL_HS     = 8'h10;
   localparam logic [7:0] SEL_STALL  = 8'h20;
   localparam logic [7:0] SEL_FIRST  = 8'h30;
   localparam logic [7:0] SEL_CAP    = 8'h40;
   localparam logic [7:0] SEL_HIT    = 8'h50;
   localparam logic [7:0] SEL_WDOG   = 8'h60;

   // First-valid readout when a channel never raised valid during the run
   localparam logic [31:0] FIRST_NONE = 32'hFFFF_FFFF;

   // Page number of a readout select
   function automatic logic [3:0] sel_page(input logic [7:0] sel);
      return sel[7:4];
   endfunction

endpackage

// File: rtl/hs_ch_stat.sv
// hs_ch_stat: sticky flags, saturating handshake/stall counters and first-valid stamp for one channel.
// Latency: statistics update on the clock edge that samples the channel; readout word is combinational.
// Backpressure: none, passive observer of vld/rdy.
module hs_ch_stat
   import hs_monitor_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_run,
   input  logic             i_vld,
   input  logic             i_rdy,
   input  logic [CNT_W-1:0] i_timer,
   output logic             o_vld_seen,
   output logic             o_rdy_seen,
   output logic [CNT_W-1:0] o_hs_cnt,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [31:0]      o_first_rd
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             r_vld_seen;
   logic             r_rdy_seen;
   logic [CNT_W-1:0] r_hs_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_first_vld;

   // Accumulate channel statistics during a run; arm wipes them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_seen  <= 1'b0;
         r_rdy_seen  <= 1'b0;
         r_hs_cnt    <= '0;
         r_stall_cnt <= '0;
         r_first_vld <= '0;
      end else if (i_clr) begin
         r_vld_seen  <= 1'b0;
         r_rdy_seen  <= 1'b0;
         r_hs_cnt    <= '0;
         r_stall_cnt <= '0;
         r_first_vld <= '0;
      end else if (i_run) begin
         if (i_vld) r_vld_seen <= 1'b1;
         if (i_rdy) r_rdy_seen <= 1'b1;
         if (i_vld && i_rdy && (r_hs_cnt != CNT_MAX))
            r_hs_cnt <= r_hs_cnt + 1'b1;
         if (i_vld && !i_rdy && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         // The timer still holds this cycle's index, so the first run cycle stamps 0
         if (i_vld && !r_vld_seen)
            r_first_vld <= i_timer;
      end
   end

   assign o_vld_seen  = r_vld_seen;
   assign o_rdy_seen  = r_rdy_seen;
   assign o_hs_cnt    = r_hs_cnt;
   assign o_stall_cnt = r_stall_cnt;
   assign o_first_rd  = r_vld_seen ? 32'(r_first_vld) : FIRST_NONE;

endmodule

// File: rtl/hs_monitor.sv
// hs_monitor: run-controlled vld/rdy debug monitor with per-channel stats, address-triggered captures and a 32-bit readout.
// Latency: statistics update on the sampling edge; rd_data_o is registered, one cycle after rd_sel_i.
// Backpressure: none, observes only and never stalls the watched pipeline.
// Optional watchdog (idle-with-valid detector, hang_o and snapshot at 0x60) is built when MON_WATCHDOG_EN is defined.
module hs_monitor
   import hs_monitor_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int NUM_TRIG = 2,
   parameter int CNT_W    = 32,
   parameter int ADDR_W   = 16,
   parameter int CAP_W    = 32,
   parameter int CAP_LAST = 0
`ifdef MON_WATCHDOG_EN
   ,
   parameter int WDOG_LIMIT = 1024
`endif
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm_i,
   input  logic                       stop_i,
   input  logic [NUM_CH-1:0]          vld_i,
   input  logic [NUM_CH-1:0]          rdy_i,
   input  logic [ADDR_W-1:0]          addr_i,
   input  logic                       cap_en_i,
   input  logic [CAP_W-1:0]           cap_data_i,
   input  logic [NUM_TRIG*ADDR_W-1:0] trig_addr_i,
   input  logic [7:0]                 rd_sel_i,
   output logic [31:0]                rd_data_o,
   output logic [2*NUM_CH-1:0]        sticky_o,
   output logic [1:0]                 state_o,
   output logic                       hang_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t               r_state;
   logic [CNT_W-1:0]     r_timer;
   logic [CAP_W-1:0]     r_cap [NUM_TRIG];
   logic [NUM_TRIG-1:0]  r_hit;
   logic [31:0]          r_rd_data;

   logic                 w_run;
   logic [NUM_TRIG-1:0]  w_hit;
   logic [NUM_CH-1:0]    w_vld_seen;
   logic [NUM_CH-1:0]    w_rdy_seen;
   logic [CNT_W-1:0]     w_hs_cnt    [NUM_CH];
   logic [CNT_W-1:0]     w_stall_cnt [NUM_CH];
   logic [31:0]          w_first_rd  [NUM_CH];
   logic [31:0]          w_wdog_rd;
   logic [31:0]          w_rd;
   logic [3:0]           w_idx;

   // Statistics only move in RUN cycles that are not themselves an arm
   assign w_run = (r_state == ST_RUN) && !arm_i;

   // Run-control FSM and the run timer; arm wins over stop and restarts from any state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
      end else if (arm_i) begin
         r_state <= ST_RUN;
         r_timer <= '0;
      end else if (r_state == ST_RUN) begin
         if (stop_i || (r_timer == CNT_MAX))
            r_state <= ST_DONE;
         if (r_timer != CNT_MAX)
            r_timer <= r_timer + 1'b1;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      hs_ch_stat #(.CNT_W(CNT_W)) u_ch (
         .clk         (clk),
         .rst         (rst),
         .i_clr       (arm_i),
         .i_run       (w_run),
         .i_vld       (vld_i[c]),
         .i_rdy       (rdy_i[c]),
         .i_timer     (r_timer),
         .o_vld_seen  (w_vld_seen[c]),
         .o_rdy_seen  (w_rdy_seen[c]),
         .o_hs_cnt    (w_hs_cnt[c]),
         .o_stall_cnt (w_stall_cnt[c]),
         .o_first_rd  (w_first_rd[c])
      );
   end

   // Address match per capture slot, qualified by cap_en_i and RUN
   always_comb begin
      w_hit = '0;
      for (int k = 0; k < NUM_TRIG; k++)
         w_hit[k] = w_run && cap_en_i && (addr_i == trig_addr_i[k*ADDR_W +: ADDR_W]);
   end

   // Capture slots: first hit only, or every hit when CAP_LAST is set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit <= '0;
         for (int k = 0; k < NUM_TRIG; k++) r_cap[k] <= '0;
      end else if (arm_i) begin
         r_hit <= '0;
         for (int k = 0; k < NUM_TRIG; k++) r_cap[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_TRIG; k++) begin
            if (w_hit[k]) begin
               r_hit[k] <= 1'b1;
               if ((CAP_LAST != 0) || !r_hit[k])
                  r_cap[k] <= cap_data_i;
            end
         end
      end
   end

`ifdef MON_WATCHDOG_EN
   logic [31:0]         r_idle;
   logic                r_hang;
   logic [2*NUM_CH-1:0] r_wdog_snap;

   // Count consecutive-ish cycles with pending valid but no handshake; latch hang and the vld/rdy picture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle      <= '0;
         r_hang      <= 1'b0;
         r_wdog_snap <= '0;
      end else if (arm_i) begin
         r_idle      <= '0;
         r_hang      <= 1'b0;
         r_wdog_snap <= '0;
      end else if (r_state == ST_RUN) begin
         if (|(vld_i & rdy_i)) begin
            r_idle <= '0;
         end else if ((|vld_i) && !r_hang) begin
            r_idle <= r_idle + 32'd1;
            if ((r_idle + 32'd1) == 32'(WDOG_LIMIT)) begin
               r_hang      <= 1'b1;
               r_wdog_snap <= {vld_i, rdy_i};
            end
         end
      end
   end

   assign hang_o    = r_hang;
   assign w_wdog_rd = 32'(r_wdog_snap);
`else
   assign hang_o    = 1'b0;
   assign w_wdog_rd = '0;
`endif

   // Readout mux; out-of-range channel/slot indices and unmapped selects read 0
   always_comb begin
      w_rd  = '0;
      w_idx = rd_sel_i[3:0];
      case (sel_page(rd_sel_i))
         sel_page(SEL_STATUS): begin
            if (rd_sel_i == SEL_STATUS)     w_rd = {28'b0, hang_o, 1'b0, r_state};
            else if (rd_sel_i == SEL_TIMER) w_rd = 32'(r_timer);
            else if (rd_sel_i == SEL_NCH)   w_rd = 32'(NUM_CH);
            else if (rd_sel_i == SEL_NTRIG) w_rd = 32'(NUM_TRIG);
         end
         sel_page(SEL_HS):
            for (int c = 0; c < NUM_CH; c++)
               if (w_idx == 4'(c)) w_rd = 32'(w_hs_cnt[c]);
         sel_page(SEL_STALL):
            for (int c = 0; c < NUM_CH; c++)
               if (w_idx == 4'(c)) w_rd = 32'(w_stall_cnt[c]);
         sel_page(SEL_FIRST):
            for (int c = 0; c < NUM_CH; c++)
               if (w_idx == 4'(c)) w_rd = w_first_rd[c];
         sel_page(SEL_CAP):
            for (int k = 0; k < NUM_TRIG; k++)
               if (w_idx == 4'(k)) w_rd = 32'(r_cap[k]);
         sel_page(SEL_HIT):
            if (w_idx == 4'd0) w_rd = 32'(r_hit);
         sel_page(SEL_WDOG):
            if (w_idx == 4'd0) w_rd = w_wdog_rd;
         default: w_rd = '0;
      endcase
   end

   // Register the selected word for the debug port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rd_data <= '0;
      else     r_rd_data <= w_rd;
   end

   assign rd_data_o = r_rd_data;
   assign sticky_o  = {w_vld_seen, w_rdy_seen};
   assign state_o   = r_state;

endmodule

// File: tb/tb_hs_monitor.sv
// tb_hs_monitor: scoreboard bench for hs_monitor; two instances differ only in CAP_LAST.
// Latency: reads expected one cycle after the select is driven.
// Backpressure: n/a.
module tb_hs_monitor;

   localparam int NUM_CH   = 4;
   localparam int NUM_TRIG = 2;
   localparam int CNT_W    = 8;
   localparam int ADDR_W   = 16;
   localparam int CAP_W    = 32;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       arm, stop;
   logic [NUM_CH-1:0]          vld, rdy;
   logic [ADDR_W-1:0]          addr;
   logic                       cap_en;
   logic [CAP_W-1:0]           cap_data;
   logic [NUM_TRIG*ADDR_W-1:0] trig_addr;
   logic [7:0]                 rd_sel;

   logic [31:0]         rd0, rd1;
   logic [2*NUM_CH-1:0] sticky0, sticky1;
   logic [1:0]          st0, st1;
   logic                hang0, hang1;

   int n_chk = 0;
   int n_bad = 0;

   string       tag_q[$];
   int          dut_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   hs_monitor #(
      .NUM_CH(NUM_CH), .NUM_TRIG(NUM_TRIG), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
      .CAP_W(CAP_W), .CAP_LAST(0)
`ifdef MON_WATCHDOG_EN
      , .WDOG_LIMIT(16)
`endif
   ) u_dut0 (
      .clk(clk), .rst(rst), .arm_i(arm), .stop_i(stop), .vld_i(vld), .rdy_i(rdy),
      .addr_i(addr), .cap_en_i(cap_en), .cap_data_i(cap_data), .trig_addr_i(trig_addr),
      .rd_sel_i(rd_sel), .rd_data_o(rd0), .sticky_o(sticky0), .state_o(st0), .hang_o(hang0)
   );

   hs_monitor #(
      .NUM_CH(NUM_CH), .NUM_TRIG(NUM_TRIG), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
      .CAP_W(CAP_W), .CAP_LAST(1)
`ifdef MON_WATCHDOG_EN
      , .WDOG_LIMIT(16)
`endif
   ) u_dut1 (
      .clk(clk), .rst(rst), .arm_i(arm), .stop_i(stop), .vld_i(vld), .rdy_i(rdy),
      .addr_i(addr), .cap_en_i(cap_en), .cap_data_i(cap_data), .trig_addr_i(trig_addr),
      .rd_sel_i(rd_sel), .rd_data_o(rd1), .sticky_o(sticky1), .state_o(st1), .hang_o(hang1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive a select, queue the expected word, compare when the registered port updates
   task automatic rd(input string tag, input int dut, input logic [7:0] sel, input logic [31:0] exp);
      string       t;
      int          d;
      logic [31:0] e;
      rd_sel = sel;
      tag_q.push_back(tag);
      dut_q.push_back(dut);
      exp_q.push_back(exp);
      @(negedge clk);
      t = tag_q.pop_front();
      d = dut_q.pop_front();
      e = exp_q.pop_front();
      chk(t, (d == 1) ? rd1 : rd0, e);
   endtask

   task automatic idle();
      arm = 1'b0; stop = 1'b0; vld = '0; rdy = '0; cap_en = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1);
   end

   initial begin
      logic [9:0] pat;
      rst = 1'b1;
      idle();
      addr = '0; cap_data = '0; rd_sel = '0;
      trig_addr = {16'd20, 16'd10};
      tick(2);
      chk("rst_state0", 32'(st0), 32'd0);
      chk("rst_state1", 32'(st1), 32'd0);
      chk("rst_sticky", 32'(sticky0), 32'd0);
      chk("rst_rd", rd0, 32'd0);
      chk("rst_hang", 32'(hang0), 32'd0);
      rst = 1'b0;
      rd("rst_status", 0, 8'h00, 32'd0);
      rd("rst_timer", 0, 8'h01, 32'd0);
      rd("rst_hs0", 0, 8'h10, 32'd0);
      rd("nch", 0, 8'h02, 32'd4);
      rd("ntrig", 0, 8'h03, 32'd2);

      // Traffic run: ch0 vld for 10 cycles with 6 readies, ch3 stalls from cycle 3
      do_arm();
      chk("armed_state", 32'(st0), 32'd1);
      pat = 10'b1110010011;
      for (int i = 0; i < 10; i++) begin
         vld[0] = 1'b1;
         rdy[0] = pat[i];
         vld[3] = (i >= 3);
         tick(1);
      end
      idle();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("stop_state", 32'(st0), 32'd2);
      chk("sticky_a", 32'(sticky0), 32'h91);
      chk("sticky_a1", 32'(sticky1), 32'h91);
      rd("hs0", 0, 8'h10, 32'd6);
      rd("stall0", 0, 8'h20, 32'd4);
      rd("first0", 0, 8'h30, 32'd0);
      rd("first1", 0, 8'h31, 32'hFFFF_FFFF);
      rd("first3", 0, 8'h33, 32'd3);
      rd("stall3", 0, 8'h23, 32'd7);
      rd("timer_a", 0, 8'h01, 32'd11);
      rd("status_done", 0, 8'h00, 32'd2);
      rd("oob_ch", 0, 8'h14, 32'd0);
      rd("unmapped", 0, 8'h7F, 32'd0);
      // DONE ignores traffic
      vld[0] = 1'b1; rdy[0] = 1'b1;
      tick(3);
      idle();
      rd("done_hs0", 0, 8'h10, 32'd6);
      rd("done_timer", 0, 8'h01, 32'd11);

      // Capture run
      do_arm();
      cap_en = 1'b1; addr = 16'd10; cap_data = 32'hAA; tick(1);
      cap_data = 32'hBB; tick(1);
      cap_en = 1'b0; addr = 16'd20; cap_data = 32'h11; tick(1);
      cap_en = 1'b1; cap_data = 32'hCC; tick(1);
      idle();
      stop = 1'b1; tick(1); stop = 1'b0;
      rd("cap0_first", 0, 8'h40, 32'hAA);
      rd("cap1_first", 0, 8'h41, 32'hCC);
      rd("hit_first", 0, 8'h50, 32'h3);
      rd("cap0_last", 1, 8'h40, 32'hBB);
      rd("cap1_last", 1, 8'h41, 32'hCC);
      rd("oob_cap", 0, 8'h42, 32'd0);
      cap_en = 1'b1; addr = 16'd10; cap_data = 32'h77; tick(1);
      idle();
      rd("done_cap", 1, 8'h40, 32'hBB);

      // Both slots on one address, same-cycle double hit; arm must clear old hits
      trig_addr = {16'd10, 16'd10};
      do_arm();
      cap_en = 1'b1; addr = 16'd10; cap_data = 32'h55; tick(1);
      idle();
      stop = 1'b1; tick(1); stop = 1'b0;
      rd("dbl_cap0", 0, 8'h40, 32'h55);
      rd("dbl_cap1", 0, 8'h41, 32'h55);
      rd("dbl_hit", 0, 8'h50, 32'h3);

      // arm and stop together: arm wins and clears
      arm = 1'b1; stop = 1'b1; tick(1);
      arm = 1'b0; stop = 1'b0;
      chk("armstop_state", 32'(st0), 32'd1);
      rd("armstop_hit", 0, 8'h50, 32'd0);
      rd("armstop_cap", 0, 8'h40, 32'd0);

      // arm during RUN clears counters, and the arm cycle itself is not counted
      vld[1] = 1'b1; rdy[1] = 1'b1;
      tick(3);
      arm = 1'b1; tick(1);
      idle();
      chk("rearm_sticky", 32'(sticky0), 32'd0);
      rd("rearm_timer", 0, 8'h01, 32'd0);
      rd("rearm_hs1", 0, 8'h11, 32'd0);
      chk("rearm_state", 32'(st0), 32'd1);

      // Reset mid-run
      rd_sel = 8'h12;
      vld[2] = 1'b1; rdy[2] = 1'b1;
      tick(4);
      #2 rst = 1'b1;
      #1;
      chk("mrst_state", 32'(st0), 32'd0);
      chk("mrst_sticky", 32'(sticky0), 32'd0);
      chk("mrst_rd", rd0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      rd("mrst_hs2", 0, 8'h12, 32'd0);
      rd("mrst_timer", 0, 8'h01, 32'd0);
      rd("mrst_first2", 0, 8'h32, 32'hFFFF_FFFF);

      // Saturation with CNT_W=8: timer tops out and forces DONE on cycle 256
      do_arm();
      vld[1] = 1'b1; rdy[1] = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick(1);
         if (i == 255) chk("sat_state_run", 32'(st0), 32'd1);
         if (i == 256) chk("sat_state_done", 32'(st0), 32'd2);
      end
      idle();
      rd("sat_hs1", 0, 8'h11, 32'd255);
      rd("sat_timer", 0, 8'h01, 32'd255);
      rd("sat_first1", 0, 8'h31, 32'd0);
      vld[1] = 1'b1; rdy[1] = 1'b0; vld[0] = 1'b1;
      tick(5);
      idle();
      rd("sat_stall1", 0, 8'h21, 32'd0);
      chk("sat_sticky", 32'(sticky0), 32'h22);

      // Watchdog: 16 stalled cycles on ch2
      do_arm();
      vld[2] = 1'b1;
      tick(15);
      chk("wd_hang_pre", 32'(hang0), 32'd0);
      tick(1);
      idle();
`ifdef MON_WATCHDOG_EN
      chk("wd_hang", 32'(hang0), 32'd1);
      rd("wd_snap", 0, 8'h60, 32'h40);
      rd("wd_status", 0, 8'h00, 32'h9);
`else
      chk("wd_hang", 32'(hang0), 32'd0);
      rd("wd_snap", 0, 8'h60, 32'd0);
      rd("wd_status", 0, 8'h00, 32'h1);
`endif
      do_arm();
      chk("wd_arm_clr", 32'(hang0), 32'd0);
      vld[2] = 1'b1;
      tick(10);
      rdy[2] = 1'b1; tick(1);
      rdy[2] = 1'b0; tick(15);
      idle();
      chk("wd_hs_clear", 32'(hang0), 32'd0);
      rd("wd_snap_none", 0, 8'h60, 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
